// File: rtl/avionics_pkg.sv
// Shared definitions for the avionics command path: FSM state encoding,
// error cause codes and the default packet start marker.
package avionics_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_ID   = 3'd1,
    ST_GET_LEN  = 3'd2,
    ST_GET_PAY  = 3'd3,
    ST_GET_CSUM = 3'd4
  } rx_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_CSUM    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } rx_err_e;

endpackage

// File: rtl/cmd_rx_timer.sv
// Inter-byte gap counter: counts enabled cycles since the last clear and
// flags the cycle in which the count sits at CYCLES-1.
module cmd_rx_timer #(
  parameter int unsigned CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] cnt_q;

  // Holds at LAST so a stalled enable never wraps back to a short count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire_o = en_i && !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/cmd_rx.sv
// Ground-link command receiver: frames SYNC/ID/LEN/PAYLOAD/CSUM packets,
// checks length and XOR checksum, and presents good commands for one cycle.
//
// state       | meaning
// ST_IDLE     | waiting for SYNC_BYTE, other bytes dropped
// ST_GET_ID   | next byte is the command id
// ST_GET_LEN  | next byte is the payload length
// ST_GET_PAY  | collecting payload bytes
// ST_GET_CSUM | next byte is the checksum, commit or drop
module cmd_rx
  import avionics_pkg::*;
#(
  parameter int          MAX_LEN        = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_data,
  input  logic                   new_rx_data,
  output logic                   cmd_valid,
  output logic [7:0]             cmd_id,
  output logic [3:0]             cmd_len,
  output logic [8*MAX_LEN-1:0]   cmd_payload,
  output logic                   err,
  output logic [1:0]             err_code,
  output logic                   busy
);

  rx_state_e            state_q;
  logic [7:0]           xor_q;
  logic [7:0]           id_q;
  logic [3:0]           len_q;
  logic [3:0]           idx_q;
  logic [7:0]           pay_q [MAX_LEN];
  logic                 cmd_valid_q;
  logic [7:0]           cmd_id_q;
  logic [3:0]           cmd_len_q;
  logic [8*MAX_LEN-1:0] cmd_payload_q;
  logic                 err_q;
  logic [1:0]           err_code_q;
  logic                 tmr_expire;

  cmd_rx_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (new_rx_data || (state_q == ST_IDLE)),
    .en_i     (state_q != ST_IDLE),
    .expire_o (tmr_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      xor_q         <= '0;
      id_q          <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      for (int i = 0; i < MAX_LEN; i++) pay_q[i] <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_id_q      <= '0;
      cmd_len_q     <= '0;
      cmd_payload_q <= '0;
      err_q         <= 1'b0;
      err_code_q    <= '0;
    end else begin
      cmd_valid_q <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (new_rx_data && (rx_data == SYNC_BYTE)) state_q <= ST_GET_ID;
        end
        ST_GET_ID: begin
          if (new_rx_data) begin
            id_q    <= rx_data;
            xor_q   <= rx_data;
            state_q <= ST_GET_LEN;
          end
        end
        ST_GET_LEN: begin
          if (new_rx_data) begin
            // Full 8-bit compare: a length with a legal low nibble is still rejected.
            if (rx_data > 8'(MAX_LEN)) begin
              err_q      <= 1'b1;
              err_code_q <= ERR_LEN;
              state_q    <= ST_IDLE;
            end else begin
              xor_q   <= xor_q ^ rx_data;
              len_q   <= rx_data[3:0];
              idx_q   <= '0;
              state_q <= (rx_data == 8'd0) ? ST_GET_CSUM : ST_GET_PAY;
            end
          end
        end
        ST_GET_PAY: begin
          if (new_rx_data) begin
            for (int i = 0; i < MAX_LEN; i++) begin
              if (idx_q == 4'(i)) pay_q[i] <= rx_data;
            end
            xor_q <= xor_q ^ rx_data;
            idx_q <= idx_q + 4'd1;
            if ((idx_q + 4'd1) == len_q) state_q <= ST_GET_CSUM;
          end
        end
        ST_GET_CSUM: begin
          if (new_rx_data) begin
            if (rx_data == xor_q) begin
              cmd_valid_q <= 1'b1;
              cmd_id_q    <= id_q;
              cmd_len_q   <= len_q;
              // Shadow bytes beyond LEN may be stale from an earlier longer packet.
              for (int i = 0; i < MAX_LEN; i++) begin
                cmd_payload_q[8*i +: 8] <= (4'(i) < len_q) ? pay_q[i] : 8'h00;
              end
            end else begin
              err_q      <= 1'b1;
              err_code_q <= ERR_CSUM;
            end
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      // A strobe in the expiry cycle is processed above and suppresses the timeout.
      if (!new_rx_data && tmr_expire) begin
        err_q      <= 1'b1;
        err_code_q <= ERR_TIMEOUT;
        state_q    <= ST_IDLE;
      end
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_id      = cmd_id_q;
  assign cmd_len     = cmd_len_q;
  assign cmd_payload = cmd_payload_q;
  assign err         = err_q;
  assign err_code    = err_code_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
